// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from one full-adder cell and a carry flop, LSB first.
// Latency: start accepted at T -> busy T+1..T+WIDTH, done pulse and result at T+WIDTH+1.
// Optional macro SERIAL_ADDER_SUB_EN adds the sub port (A-B via ~B and carry-in 1); start ignored while busy.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 low result bits; the MSB comes straight from the cell on the last step.
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_ext;
  logic             cff;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_out;
  logic             last;
  logic             load;
  logic             sub_cap;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_cap = sub;
`else
  assign sub_cap = 1'b0;
`endif

  // Single full-adder cell on the register LSBs plus the shifted result view.
  always_comb begin
    s_bit   = a_sr[0] ^ b_sr[0] ^ cff;
    c_out   = (a_sr[0] & b_sr[0]) | (cff & (a_sr[0] ^ b_sr[0]));
    res_ext = {s_bit, res_sr};
    last    = (cnt == CW'(WIDTH - 1));
  end

  // Next-state decode and handshake outputs; DONE accepts start like IDLE for back-to-back use.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture, one bit per cycle while running, and result publish on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cff      <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      a_sr <= a;
      b_sr <= sub_cap ? ~b : b;
      cff  <= sub_cap;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_ext[WIDTH-1:1];
      cff    <= c_out;
      if (last) begin
        // cff still holds the carry into the MSB here, so the overflow XOR is formed directly.
        sum      <= res_ext;
        carry    <= c_out;
        overflow <= c_out ^ cff;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
